// File: rtl/fp_mult_arbiter.sv
// Round-robin share of one fixed-latency pipelined FP multiplier core among NUM_REQ requesters.
// Latency: grant cycle to resp_valid_out is MULT_LATENCY+2 cycles; one issue per cycle.
// Backpressure: requesters hold valid until granted; responses and core results cannot be stalled.
module fp_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MULT_LATENCY = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [DATA_WIDTH-1:0]         mult_a_out,
    output logic [DATA_WIDTH-1:0]         mult_b_out,
    output logic                          mult_valid_out,
    input  logic [DATA_WIDTH-1:0]         mult_result_in,
    input  logic                          mult_result_valid_in,
    output logic [DATA_WIDTH-1:0]         resp_data_out,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic                          busy_out,
    output logic                          tag_error_out
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DRAIN_W = $clog2(MULT_LATENCY + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MULT_LATENCY + 1);

    logic [IDX_W-1:0]        r_last_grant;
    logic [IDX_W-1:0]        r_issue_idx;
    logic [DRAIN_W-1:0]      r_drain_cnt;
    logic [MULT_LATENCY-1:0] r_tag_vld;
    logic [IDX_W-1:0]        r_tag_idx [MULT_LATENCY];

    logic             w_drain;
    logic             w_block;
    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_xfer;
    logic             w_tail_vld;
    logic [IDX_W-1:0] w_tail_idx;

    // The core keeps emitting results after our reset; ignore its output until it has flushed.
    assign w_drain    = (r_drain_cnt != '0);
    assign w_block    = rst_in | w_drain;
    assign w_tail_vld = r_tag_vld[MULT_LATENCY-1];
    assign w_tail_idx = r_tag_idx[MULT_LATENCY-1];

    // Round-robin search starting one past the last granted requester.
    always_comb begin : grant_search
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_grant_vld && req_valid_in[IDX_W'(idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(idx);
            end
        end
    end

    assign w_xfer        = w_grant_vld & ~w_block;
    assign req_ready_out = w_xfer ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign busy_out      = mult_valid_out | (|r_tag_vld);

    // Register the granted operands towards the core and advance the round-robin pointer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_last_grant   <= IDX_W'(NUM_REQ - 1);
            r_issue_idx    <= '0;
            mult_valid_out <= 1'b0;
            mult_a_out     <= '0;
            mult_b_out     <= '0;
        end else begin
            mult_valid_out <= w_xfer;
            if (w_xfer) begin
                r_last_grant <= w_grant_idx;
                r_issue_idx  <= w_grant_idx;
                mult_a_out   <= req_a_in[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                mult_b_out   <= req_b_in[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Drain window counter: held at full while in reset, counts down afterwards.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_drain_cnt <= DRAIN_LOAD;
        end else if (w_drain) begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
        end
    end

    // Tag pipeline mirrors the core latency so the tail lines up with the core result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tag_vld <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= mult_valid_out;
            r_tag_idx[0] <= r_issue_idx;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    // Route the core result to the owning requester; flag any result/tag disagreement.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            resp_data_out  <= '0;
            resp_valid_out <= '0;
            tag_error_out  <= 1'b0;
        end else begin
            resp_valid_out <= '0;
            if (!w_drain) begin
                if (mult_result_valid_in && w_tail_vld) begin
                    resp_data_out  <= mult_result_in;
                    resp_valid_out <= NUM_REQ'(1) << w_tail_idx;
                end else if (mult_result_valid_in != w_tail_vld) begin
                    tag_error_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter with a behavioural multiplier core and a scoreboard of expected products.
// Latency: expects each response exactly L+2 cycles after its grant.
// Backpressure: requesters hold operands until granted; responses are never stalled.
module tb_fp_mult_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 8;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [N-1:0]      req_valid_in = '0;
    logic [N*DW-1:0]   req_a_in = '0;
    logic [N*DW-1:0]   req_b_in = '0;
    logic [N-1:0]      req_ready_out;
    logic [DW-1:0]     mult_a_out;
    logic [DW-1:0]     mult_b_out;
    logic              mult_valid_out;
    logic [DW-1:0]     mult_result_in = '0;
    logic              mult_result_valid_in = 1'b0;
    logic [DW-1:0]     resp_data_out;
    logic [N-1:0]      resp_valid_out;
    logic              busy_out;
    logic              tag_error_out;

    fp_mult_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MULT_LATENCY(L)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .req_valid_in         (req_valid_in),
        .req_a_in             (req_a_in),
        .req_b_in             (req_b_in),
        .req_ready_out        (req_ready_out),
        .mult_a_out           (mult_a_out),
        .mult_b_out           (mult_b_out),
        .mult_valid_out       (mult_valid_out),
        .mult_result_in       (mult_result_in),
        .mult_result_valid_in (mult_result_valid_in),
        .resp_data_out        (resp_data_out),
        .resp_valid_out       (resp_valid_out),
        .busy_out             (busy_out),
        .tag_error_out        (tag_error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          g;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [N-1:0] want = '0;
    logic [N-1:0] pend_v = '0;
    logic [31:0] pend_a [N];
    logic [31:0] pend_b [N];
    logic [31:0] pend_e [N];
    int          tb_last = N - 1;
    int          tb_drain = 0;
    logic        exp_mv = 1'b0;
    logic [31:0] exp_ma = '0;
    logic [31:0] exp_mb = '0;
    logic        exp_err = 1'b0;
    logic        rst_req = 1'b1;
    logic        rst_prev = 1'b1;
    bit          mon_en = 1'b0;
    bit          inject = 1'b0;
    bit          core_v [64];
    bit [31:0]   core_d [64];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Exact single-precision product for operands whose mantissas fit in a few bits.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        logic [10:0] e;
        da = {a[31], {3'b0, a[30:23]} + 11'd896, a[22:0], 29'b0};
        db = {b[31], {3'b0, b[30:23]} + 11'd896, b[22:0], 29'b0};
        dp = $realtobits($bitstoreal(da) * $bitstoreal(db));
        e  = dp[62:52] - 11'd896;
        return {dp[63], e[7:0], dp[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex, mt;
        ex = 8'($urandom_range(100, 154));
        mt = 8'($urandom_range(0, 255));
        return {1'($urandom_range(0, 1)), ex, mt, 15'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_a_in[i*DW +: DW] = pend_a[i];
            req_b_in[i*DW +: DW] = pend_b[i];
        end
        req_valid_in = pend_v;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
        pend_e[i] = e;
        drive_reqs();
    endtask

    // One clock: check grant and issue against the round-robin rule, then refresh requesters.
    task automatic cycle();
        int g;
        int j;
        logic [31:0] a, b;
        @(negedge clk_in);
        g = -1;
        if (!rst_in && tb_drain == 0) begin
            for (int k = 1; k <= N; k++) begin
                j = (tb_last + k) % N;
                if (g < 0 && pend_v[j]) g = j;
            end
        end
        if (rst_in) tb_drain = L + 1;
        else if (tb_drain > 0) tb_drain--;
        if (rst_in && rst_prev) begin
            chk("reset_mult_a", mult_a_out, 0);
            chk("reset_mult_b", mult_b_out, 0);
            chk("reset_resp_data", resp_data_out, 0);
        end
        rst_prev = rst_in;
        chk("grant", req_ready_out, (g < 0) ? 0 : (1 << g));
        chk("mult_valid", mult_valid_out, exp_mv);
        if (exp_mv) begin
            chk("mult_a", mult_a_out, exp_ma);
            chk("mult_b", mult_b_out, exp_mb);
        end
        exp_mv = (g >= 0);
        if (g >= 0) begin
            exp_ma  = pend_a[g];
            exp_mb  = pend_b[g];
            sb.push_back('{g, pend_e[g], cyc, cyc + L + 2});
            tb_last = g;
            pend_v[g] = 1'b0;
        end
        @(posedge clk_in);
        if (rst_in) begin
            sb.delete();
            pend_v  = '0;
            tb_last = N - 1;
            exp_err = 1'b0;
            exp_mv  = 1'b0;
        end
        #1;
        rst_in = rst_req;
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && want[i]) begin
                a = rand_fp();
                b = rand_fp();
                set_op(i, a, b, fmul(a, b));
            end
        end
        drive_reqs();
    endtask

    task automatic apply_reset();
        want    = '0;
        rst_req = 1'b1;
        cycle();
        cycle();
        rst_req = 1'b0;
        cycle();
    endtask

    // Multiplier core model: fixed latency, no reset, always emits what it was fed.
    always @(negedge clk_in) begin
        core_v[(cyc + L) % 64] <= mult_valid_out;
        core_d[(cyc + L) % 64] <= fmul(mult_a_out, mult_b_out);
    end

    always @(posedge clk_in) begin
        #2;
        mult_result_valid_in = core_v[cyc % 64] | inject;
        mult_result_in       = inject ? 32'h3f800000 : core_d[cyc % 64];
    end

    // Monitor: pop the scoreboard whenever a response appears and check flags every cycle.
    always @(negedge clk_in) begin
        exp_t e;
        logic exp_b;
        if (mon_en) begin
            chk("tag_error", tag_error_out, exp_err);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_missing: got none expected req %0d due cycle %0d", sb[0].idx, sb[0].due);
                void'(sb.pop_front());
            end
            if (resp_valid_out != '0) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("resp_owner", resp_valid_out, 1 << e.idx);
                    chk("resp_data", resp_data_out, e.data);
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL resp_unexpected: got valid %b data %h expected no response (cycle %0d)",
                             resp_valid_out, resp_data_out, cyc);
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_missing: got none expected req %0d at cycle %0d", sb[0].idx, cyc);
                void'(sb.pop_front());
            end
            exp_b = 1'b0;
            foreach (sb[i]) if (sb[i].g < cyc) exp_b = 1'b1;
            chk("busy", busy_out, exp_b);
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend_a[i] = '0;
            pend_b[i] = '0;
            pend_e[i] = '0;
        end
        repeat (2) @(posedge clk_in);
        #1;
        mon_en  = 1'b1;
        rst_req = 1'b0;

        // Single request 2.0 x 3.0, issued while still in the drain window.
        set_op(0, 32'h40000000, 32'h40400000, 32'h40C00000);
        repeat (L + 1 + L + 6) cycle();

        // All four requesters continuously from a fresh pointer.
        apply_reset();
        repeat (L + 1) cycle();
        want = 4'b1111;
        repeat (8) cycle();
        want = '0;
        repeat (L + 8) cycle();

        // Requester 2 alone, then 1 and 3 join.
        want = 4'b0100;
        repeat (5) cycle();
        want = 4'b1110;
        repeat (6) cycle();
        want = '0;
        repeat (L + 8) cycle();

        // Random request masks.
        for (int t = 0; t < 60; t++) begin
            want = 4'($urandom_range(0, 15));
            cycle();
        end
        want = '0;
        repeat (L + 8) cycle();

        // Idle, then all four to confirm the pointer did not move.
        repeat (20) cycle();
        want = 4'b1111;
        repeat (4) cycle();
        want = '0;
        repeat (L + 8) cycle();

        // Spurious core result with an empty pipeline.
        inject = 1'b1;
        cycle();
        inject  = 1'b0;
        exp_err = 1'b1;
        repeat (5) cycle();
        apply_reset();
        repeat (L + 2) cycle();

        // Reset with three operations in flight; stale results must be discarded.
        want = 4'b1111;
        repeat (3) cycle();
        apply_reset();
        set_op(1, 32'h3FC00000, 32'h40800000, 32'h40C00000);
        repeat (L + 1 + L + 6) cycle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
